lsu_mem_master: RTL and testbench

//   Initiator side of the data-memory port: turns single load/store requests from the pipeline into
//   mem_read/mem_write strobes with address/write_data, and returns the read word on a response handshake.

---
 rtl/lsu_pkg.sv | 14 +
 rtl/lsu_mem_master.sv | 111 +++++++++++
 tb/tb_lsu_mem_master.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and default sizes for the LSU data-memory initiator.
package lsu_pkg;

    localparam int LSU_ADDR_W    = 64;
    localparam int LSU_DATA_W    = 32;
    localparam int LSU_MEM_WORDS = 1280;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master.sv
// Initiator side of the data-memory port. A single load/store is accepted
// from the pipeline, turned into registered mem_read/mem_write strobes for
// one cycle (data_memory acts on the falling edge), and its result is
// returned on a valid/ready response handshake. One access in flight.
//
// Optional feature macro: LSU_BOUNDS_CHECK_EN
//   defined   -> requests with req_addr >= MEM_WORDS drive no strobe and
//                complete with rsp_err=1, rsp_rdata=0 at the normal latency.
//   undefined -> rsp_err is constant 0, all addresses are forwarded.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
`ifdef LSU_BOUNDS_CHECK_EN
    ,
    parameter int MEM_WORDS = LSU_MEM_WORDS
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] read_data
);

    lsu_state_e state;
    lsu_state_e state_next;
    logic       accept;
    logic       oob;       // incoming request targets a word outside data_memory
    logic       err_pend;  // the access now in ACCESS was rejected

    assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
    assign accept    = req_valid & req_ready;

`ifdef LSU_BOUNDS_CHECK_EN
    assign oob = (req_addr >= ADDR_W'(MEM_WORDS));

    // Remember whether the access being performed was rejected by the bounds check
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pend <= 1'b0;
        end else if (accept) begin
            err_pend <= oob;
        end
    end
`else
    assign oob      = 1'b0;
    assign err_pend = 1'b0;
`endif

    // Next-state decode: a rejected access still passes through ACCESS so the
    // response latency is identical to a real memory access
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_ready) state_next = accept ? ACCESS : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus all registered memory-side and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            address    <= '0;
            write_data <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;

            // Strobes are high only during the single ACCESS cycle that follows accept
            if (accept) begin
                address    <= req_addr;
                write_data <= req_wdata;
                mem_read   <= ~req_write & ~oob;
                mem_write  <= req_write & ~oob;
            end else begin
                mem_read   <= 1'b0;
                mem_write  <= 1'b0;
            end

            // mem_read is still high in ACCESS for a load, so it selects the read word
            if (state == ACCESS) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= mem_read ? read_data : '0;
                rsp_err   <= err_pend;
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master with a behavioural falling-edge data_memory.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] read_data;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rd_pulses = 0;
    int   wr_pulses = 0;
    int   last_pop = -1;
    bit   b2b = 1'b0;
    exp_t sb[$];
    vec_t vecs[8];
    logic [31:0] mem[0:1279];
    bit   mem_ready = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .write_data(write_data), .mem_write(mem_write),
        .mem_read(mem_read), .read_data(read_data)
    );

    // data_memory model: preset contents, acts on the falling edge
    always @(negedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1280; i++) mem[i] <= 32'(i * 16 + 7);
            mem[0] <= 32'd1000;
            mem[1] <= 32'd200;
            mem[4] <= 32'hFFFFFA24;
            mem[5] <= 32'd3;
            mem_ready <= 1'b1;
        end else begin
            if (mem_write && address < 64'd1280) mem[address[10:0]] <= write_data;
            if (mem_read) read_data <= (address < 64'd1280) ? mem[address[10:0]] : 32'd0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response scoreboard and strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_read) rd_pulses++;
        if (mem_write) wr_pulses++;
        if (mem_read || mem_write) chk("strobes_exclusive", {63'd0, mem_read & mem_write}, 64'd0);
        if (!b2b) last_pop = -1;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rdata %0h with nothing expected", rsp_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                if (b2b && last_pop >= 0) chk("rsp_spacing", 64'(cyc - last_pop), 64'd2);
                if (b2b) last_pop = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait (bounded) for acceptance, push its expectation
    task automatic issue(input logic wr, input logic [63:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input bit push);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req_ready %0b expected 1 addr %0d", req_ready, a);
        end else if (push) begin
            sb.push_back('{rdata: er, err: ee});
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int rd0;
        int wr0;

        vecs[0] = '{1'b0, 64'd0, 32'd0,          32'd1000,     1'b0};
        vecs[1] = '{1'b1, 64'd6, 32'hDEADBEEF,   32'd0,        1'b0};
        vecs[2] = '{1'b0, 64'd6, 32'd0,          32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 64'd4, 32'd0,          32'hFFFFFA24, 1'b0};
        vecs[4] = '{1'b0, 64'd5, 32'd0,          32'd3,        1'b0};
        vecs[5] = '{1'b1, 64'd2, 32'h12345678,   32'd0,        1'b0};
        vecs[6] = '{1'b0, 64'd2, 32'hFFFF0000,   32'h12345678, 1'b0};
        vecs[7] = '{1'b0, 64'd1, 32'd0,          32'd200,      1'b0};

        // Reset held two cycles with a request pending
        rst = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 64'd0;
        req_wdata = 32'h55AA55AA;
        rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
            chk("rst_rsp_err", 64'(rsp_err), 64'd0);
            chk("rst_mem_read", 64'(mem_read), 64'd0);
            chk("rst_mem_write", 64'(mem_write), 64'd0);
            chk("rst_address", address, 64'd0);
            chk("rst_write_data", 64'(write_data), 64'd0);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        step();
        chk("rel_no_strobe", 64'({mem_read, mem_write}), 64'd0);

        // Table of back-to-back accesses with rsp_ready held high
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        b2b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
            chk("access_strobe", 64'({mem_write, mem_read}), vecs[i].wr ? 64'd2 : 64'd1);
            chk("access_address", address, vecs[i].addr);
        end
        wait_drain();
        b2b = 1'b0;
        chk("table_rd_pulses", 64'(rd_pulses - rd0), 64'd6);
        chk("table_wr_pulses", 64'(wr_pulses - wr0), 64'd2);

        // Response stalled three cycles by rsp_ready=0
        rsp_ready = 1'b0;
        issue(1'b0, 64'd1, 32'd0, 32'd200, 1'b0, 1'b1);
        chk("stall_strobe", 64'(mem_read), 64'd1);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("stall_rsp_rdata", 64'(rsp_rdata), 64'd200);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
            chk("stall_no_strobe", 64'({mem_read, mem_write}), 64'd0);
            if (i < 2) step();
        end
        rsp_ready = 1'b1;
        step();
        chk("stall_release", 64'(rsp_valid), 64'd0);
        chk("stall_drained", 64'(sb.size()), 64'd0);

        // Address one past the end of data_memory
        rd0 = rd_pulses;
        issue(1'b0, 64'd1280, 32'd0, 32'd0, BC, 1'b1);
        wait_drain();
        chk("oob_rd_pulses", 64'(rd_pulses - rd0), BC ? 64'd0 : 64'd1);

        // Reset asserted while a load is in ACCESS
        issue(1'b0, 64'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("midrst_strobe", 64'(mem_read), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_mem_read", 64'(mem_read), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        step();
        chk("midrst_rsp_valid2", 64'(rsp_valid), 64'd0);
        step();
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
